// File: rtl/core_boot_loader.sv
// core_boot_loader: command-driven preload of imem/regfile, then core release; BOOT_CHECKSUM_EN adds an image checksum gate on GO.
module core_boot_loader #(
  parameter int XLEN = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int NUM_REGS = 32,
  parameter int MAX_BURST = 256,
  localparam int RA_W = $clog2(NUM_REGS),
  localparam int BC_W = $clog2(MAX_BURST + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_cmd_valid,
  input  logic [1:0]      i_cmd_type,
  input  logic [XLEN-1:0] i_cmd_addr,
  input  logic [XLEN-1:0] i_cmd_data,
  output logic            o_cmd_ready,
  output logic            o_imem_we,
  output logic [XLEN-1:0] o_imem_addr,
  output logic [XLEN-1:0] o_imem_wdata,
  output logic            o_reg_we,
  output logic [RA_W-1:0] o_reg_addr,
  output logic [XLEN-1:0] o_reg_wdata,
  output logic            o_setup,
  output logic            o_core_run,
  output logic [XLEN-1:0] o_start_pc,
  output logic            o_err,
  output logic [1:0]      o_err_code
`ifdef BOOT_CHECKSUM_EN
  , output logic [XLEN-1:0] o_checksum
`endif
);
  typedef enum logic [1:0] {LOAD, BURST, RUN, ERR} state_t;
  localparam logic [XLEN-1:0] IMEM_LIM = XLEN'(IMEM_DEPTH * 4);
  state_t r_state, w_next;
  logic [BC_W-1:0] r_rem;
  logic [XLEN-1:0] r_ptr;
  logic [XLEN-1:0] r_imem_addr, r_imem_wdata, r_reg_wdata, r_start_pc;
  logic [RA_W-1:0] r_reg_addr;
  logic            r_imem_we, r_reg_we;
  logic [1:0]      r_err_code;
  logic [1:0]      w_code;
  logic            w_fire, w_addr_ok, w_reg_ok, w_ptr_ok, w_pc_ok;
  logic            w_iwe, w_rwe, w_bstart;
  logic [XLEN-1:0] w_iaddr;
`ifdef BOOT_CHECKSUM_EN
  logic [XLEN-1:0] r_checksum;
  assign o_checksum = r_checksum;
  assign w_pc_ok = i_cmd_data[1:0] == 2'b00 && i_cmd_addr == r_checksum;
`else
  assign w_pc_ok = i_cmd_data[1:0] == 2'b00;
`endif
  assign o_cmd_ready = !rst && (r_state == LOAD || r_state == BURST);
  assign w_fire      = i_cmd_valid && o_cmd_ready;
  assign w_addr_ok   = i_cmd_addr[1:0] == 2'b00 && i_cmd_addr < IMEM_LIM;
  assign w_reg_ok    = i_cmd_addr < XLEN'(NUM_REGS);
  assign w_ptr_ok    = r_ptr < IMEM_LIM;
  always_comb begin
    w_next   = r_state;
    w_code   = 2'b00;
    w_iwe    = 1'b0;
    w_rwe    = 1'b0;
    w_bstart = 1'b0;
    w_iaddr  = r_state == BURST ? r_ptr : i_cmd_addr;
    if (w_fire && r_state == BURST) begin
      w_iwe  = w_ptr_ok;
      w_code = w_ptr_ok ? 2'b00 : 2'b01;
      w_next = !w_ptr_ok ? ERR : r_rem == BC_W'(1) ? LOAD : BURST;
    end else if (w_fire) begin
      case (i_cmd_type)
        2'b00: begin
          w_iwe  = w_addr_ok;
          w_code = w_addr_ok ? 2'b00 : 2'b01;
        end
        2'b01: begin
          w_rwe  = w_reg_ok && i_cmd_addr != '0;
          w_code = w_reg_ok ? 2'b00 : 2'b10;
        end
        2'b10: begin
          w_code   = w_addr_ok && i_cmd_data <= XLEN'(MAX_BURST) ? 2'b00 : 2'b01;
          w_bstart = w_code == 2'b00 && i_cmd_data != '0;
          w_next   = w_bstart ? BURST : r_state;
        end
        default: begin
          w_code = w_pc_ok ? 2'b00 : 2'b11;
          w_next = w_pc_ok ? RUN : r_state;
        end
      endcase
      w_next = w_code != 2'b00 ? ERR : w_next;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LOAD;
      r_rem        <= '0;
      r_ptr        <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_reg_we     <= 1'b0;
      r_reg_addr   <= '0;
      r_reg_wdata  <= '0;
      r_start_pc   <= '0;
      r_err_code   <= 2'b00;
`ifdef BOOT_CHECKSUM_EN
      r_checksum   <= '0;
`endif
    end else begin
      r_state   <= w_next;
      r_imem_we <= w_iwe;
      r_reg_we  <= w_rwe;
      if (w_iwe) begin
        r_imem_addr  <= w_iaddr;
        r_imem_wdata <= i_cmd_data;
`ifdef BOOT_CHECKSUM_EN
        r_checksum   <= r_checksum + i_cmd_data;
`endif
      end
      if (w_rwe) begin
        r_reg_addr  <= i_cmd_addr[RA_W-1:0];
        r_reg_wdata <= i_cmd_data;
      end
      if (w_bstart) begin
        r_rem <= i_cmd_data[BC_W-1:0];
        r_ptr <= i_cmd_addr;
      end else if (w_iwe && r_state == BURST) begin
        r_rem <= r_rem - BC_W'(1);
        r_ptr <= r_ptr + XLEN'(4);
      end
      if (w_code != 2'b00) r_err_code <= w_code;
      if (w_next == RUN && r_state == LOAD) r_start_pc <= i_cmd_data;
    end
  end
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_reg_we     = r_reg_we;
  assign o_reg_addr   = r_reg_addr;
  assign o_reg_wdata  = r_reg_wdata;
  assign o_setup      = r_state != RUN;
  assign o_core_run   = r_state == RUN;
  assign o_start_pc   = r_start_pc;
  assign o_err        = r_state == ERR;
  assign o_err_code   = r_err_code;
endmodule

// File: tb/tb_core_boot_loader.sv
// tb_core_boot_loader: directed plus randomized checks of core_boot_loader against an arithmetic reference model.
module tb_core_boot_loader;
  localparam int LIM = 1024 * 4;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic [1:0]  i_cmd_type = 2'b00;
  logic [31:0] i_cmd_addr = '0;
  logic [31:0] i_cmd_data = '0;
  logic        o_cmd_ready, o_imem_we, o_reg_we, o_setup, o_core_run, o_err;
  logic [31:0] o_imem_addr, o_imem_wdata, o_reg_wdata, o_start_pc;
  logic [4:0]  o_reg_addr;
  logic [1:0]  o_err_code;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] o_checksum;
`endif
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] sum = '0;
  logic [31:0] ra, rd;
  logic [1:0]  rt;
  int          rk;
  bit          ok;

  core_boot_loader dut (
    .clk(clk), .rst(rst), .i_cmd_valid(i_cmd_valid), .i_cmd_type(i_cmd_type),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .o_cmd_ready(o_cmd_ready),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
    .o_reg_we(o_reg_we), .o_reg_addr(o_reg_addr), .o_reg_wdata(o_reg_wdata),
    .o_setup(o_setup), .o_core_run(o_core_run), .o_start_pc(o_start_pc),
    .o_err(o_err), .o_err_code(o_err_code)
`ifdef BOOT_CHECKSUM_EN
    , .o_checksum(o_checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    i_cmd_valid = 1'b1;
    i_cmd_type  = t;
    i_cmd_addr  = a;
    i_cmd_data  = d;
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit full);
    i_cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    sum = '0;
    if (full) begin
      chk("rst_ready_low", o_cmd_ready, 0);
      chk("rst_setup", o_setup, 1);
      chk("rst_run", o_core_run, 0);
      chk("rst_imem_we", o_imem_we, 0);
      chk("rst_reg_we", o_reg_we, 0);
      chk("rst_imem_addr", o_imem_addr, 0);
      chk("rst_imem_wdata", o_imem_wdata, 0);
      chk("rst_reg_addr", o_reg_addr, 0);
      chk("rst_pc", o_start_pc, 0);
      chk("rst_err", o_err, 0);
      chk("rst_code", o_err_code, 0);
`ifdef BOOT_CHECKSUM_EN
      chk("rst_sum", o_checksum, 0);
`endif
    end
    rst = 1'b0;
    #1;
    if (full) chk("rst_ready_after", o_cmd_ready, 1);
  endtask

  initial begin
    do_reset(1);
    beat(2'b00, 32'h4, 32'h00127413);
    chk("imem_we", o_imem_we, 1);
    chk("imem_addr", o_imem_addr, 32'h4);
    chk("imem_data", o_imem_wdata, 32'h00127413);
    idle();
    chk("imem_pulse", o_imem_we, 0);
    beat(2'b01, 32'd4, 32'h1);
    chk("reg_we", o_reg_we, 1);
    chk("reg_addr", o_reg_addr, 4);
    chk("reg_data", o_reg_wdata, 1);
    beat(2'b01, 32'd0, 32'h5);
    chk("reg0_nowrite", o_reg_we, 0);
    beat(2'b10, 32'h10, 32'd3);
    chk("burst_hdr_nowrite", o_imem_we, 0);
    for (int i = 0; i < 3; i++) begin
      beat(2'(i), 32'hDEAD0000, 32'hA + 32'(i));
      chk("burst_we", o_imem_we, 1);
      chk("burst_addr", o_imem_addr, 32'h10 + 32'(4 * i));
      chk("burst_data", o_imem_wdata, 32'hA + 32'(i));
    end
    beat(2'b00, 32'h20, 32'h55);
    chk("after_burst_addr", o_imem_addr, 32'h20);
    chk("after_burst_data", o_imem_wdata, 32'h55);
    beat(2'b10, 32'h40, 32'd0);
    chk("burst0_ready", o_cmd_ready, 1);
    beat(2'b00, 32'h44, 32'h1);
    chk("burst0_load_addr", o_imem_addr, 32'h44);
    chk("burst0_load_we", o_imem_we, 1);
    do_reset(0);
    // randomized single writes; any predicted error is checked then cleared by reset
    for (int i = 0; i < 60; i++) begin
      rk = $urandom_range(0, 9);
      rd = $urandom;
      rt = rk < 7 ? 2'b00 : 2'b01;
      ra = rk < 5 ? 32'($urandom_range(0, 1023) * 4) :
           rk == 5 ? 32'($urandom_range(0, 1023) * 4 + $urandom_range(1, 3)) :
           rk == 6 ? 32'(LIM + $urandom_range(0, 4000) * 4) :
           rk == 9 ? 32'($urandom_range(32, 5000)) : 32'($urandom_range(0, 31));
      ok = rt == 2'b00 ? (ra % 4 == 0 && ra < LIM) : (ra < 32);
      beat(rt, ra, rd);
      if (ok && rt == 2'b00) begin
        sum = sum + rd;
        chk("rnd_imem_we", o_imem_we, 1);
        chk("rnd_imem_addr", o_imem_addr, ra);
        chk("rnd_imem_data", o_imem_wdata, rd);
      end else if (ok) begin
        chk("rnd_reg_we", o_reg_we, ra != 0);
        if (ra != 0) chk("rnd_reg_addr", o_reg_addr, ra);
        if (ra != 0) chk("rnd_reg_data", o_reg_wdata, rd);
      end else begin
        chk("rnd_err", o_err, 1);
        chk("rnd_code", o_err_code, rt == 2'b00 ? 2'b01 : 2'b10);
        chk("rnd_err_nowrite", o_imem_we | o_reg_we, 0);
        chk("rnd_err_ready", o_cmd_ready, 0);
      end
`ifdef BOOT_CHECKSUM_EN
      chk("rnd_sum", o_checksum, sum);
`endif
      if (!ok) do_reset(0);
    end
    do_reset(0);
    beat(2'b00, 32'h6, 32'h1);
    chk("mis_err", o_err, 1);
    chk("mis_code", o_err_code, 1);
    chk("mis_ready", o_cmd_ready, 0);
    chk("mis_nowrite", o_imem_we, 0);
    beat(2'b00, 32'h8, 32'h1);
    chk("err_sticky_nowrite", o_imem_we, 0);
    do_reset(0);
    beat(2'b10, 32'((1024 - 1) * 4), 32'd2);
    beat(2'b00, 32'h0, 32'h11);
    chk("edge_we", o_imem_we, 1);
    chk("edge_addr", o_imem_addr, 32'hFFC);
    beat(2'b00, 32'h0, 32'h22);
    chk("edge2_nowrite", o_imem_we, 0);
    chk("edge2_err", o_err, 1);
    chk("edge2_code", o_err_code, 1);
    do_reset(0);
    beat(2'b10, 32'h0, 32'd300);
    chk("big_burst_code", o_err_code, 1);
    do_reset(0);
    beat(2'b11, 32'h0, 32'h6);
    chk("go_mis_err", o_err, 1);
    chk("go_mis_code", o_err_code, 3);
    chk("go_mis_run", o_core_run, 0);
    do_reset(0);
    beat(2'b11, 32'h0, 32'h4);
    chk("go_run", o_core_run, 1);
    chk("go_setup", o_setup, 0);
    chk("go_pc", o_start_pc, 32'h4);
    chk("go_ready", o_cmd_ready, 0);
    beat(2'b00, 32'h8, 32'h9);
    chk("run_nowrite", o_imem_we, 0);
    chk("run_stays", o_core_run, 1);
`ifdef BOOT_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      do_reset(0);
      beat(2'b00, 32'h0, 32'h5);
      beat(2'b00, 32'h4, 32'h7);
      chk("cs_sum", o_checksum, 32'hC);
      beat(2'b11, k == 0 ? 32'hD : 32'hC, 32'h4);
      chk("cs_run", o_core_run, k == 1);
      chk("cs_code", o_err_code, k == 0 ? 2'b11 : 2'b00);
    end
`endif
    do_reset(0);
    beat(2'b10, 32'h0, 32'd4);
    beat(2'b00, 32'h0, 32'h1);
    beat(2'b00, 32'h0, 32'h2);
    do_reset(1);
    beat(2'b00, 32'h8, 32'h3);
    chk("post_rst_addr", o_imem_addr, 32'h8);
    chk("post_rst_data", o_imem_wdata, 32'h3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
